// File: rtl/sccb_cfg_pkg.sv
// Shared definitions for the SCCB configuration sequencer.
//   cfg_state_t            : sequencer state encoding
//   DLY_MARK_DEF           : default reg_addr value marking a delay entry
//   ENTRY_W / FIELD_W      : LUT entry width and width of each field
//   ADDR_LSB / DATA_LSB    : bit positions of reg_addr and reg_data in an entry
//   entry_addr, entry_data : field extraction helpers
package sccb_cfg_pkg;

   typedef enum logic [2:0] {
      PWRON,
      FETCH,
      ISSUE,
      GAP,
      WAIT,
      DONE,
      ERR
   } cfg_state_t;

   localparam logic [7:0] DLY_MARK_DEF = 8'hFF;

   localparam int ENTRY_W  = 16;
   localparam int FIELD_W  = 8;
   localparam int ADDR_LSB = 8;
   localparam int DATA_LSB = 0;

   function automatic logic [FIELD_W-1:0] entry_addr(input logic [ENTRY_W-1:0] e);
      return e[ADDR_LSB +: FIELD_W];
   endfunction

   function automatic logic [FIELD_W-1:0] entry_data(input logic [ENTRY_W-1:0] e);
      return e[DATA_LSB +: FIELD_W];
   endfunction

endpackage

// File: rtl/sccb_cfg_sequencer_if.sv
// Write-request handshake between the configuration sequencer and the
// existing I2C/SCCB write controller.
//   i2c_req   : write request level, held until i2c_done
//   i2c_dev   : 8-bit device write address
//   i2c_addr  : register address, stable while i2c_req=1
//   i2c_wdata : register data, stable while i2c_req=1
//   i2c_done  : one-cycle completion pulse from the controller
//   i2c_nack  : qualifies i2c_done; 1 = slave did not acknowledge
// Modports: master = sequencer side, slave = I2C controller side.
interface sccb_cfg_sequencer_if;
   import sccb_cfg_pkg::*;

   logic               i2c_req;
   logic [FIELD_W-1:0] i2c_dev;
   logic [FIELD_W-1:0] i2c_addr;
   logic [FIELD_W-1:0] i2c_wdata;
   logic               i2c_done;
   logic               i2c_nack;

   modport master (
      output i2c_req, i2c_dev, i2c_addr, i2c_wdata,
      input  i2c_done, i2c_nack
   );

   modport slave (
      input  i2c_req, i2c_dev, i2c_addr, i2c_wdata,
      output i2c_done, i2c_nack
   );

endinterface

// File: rtl/sccb_cfg_delay.sv
// Loadable down-counter with zero flag, shared by the power-on, inter-write
// gap and delay-marker waits of the sequencer.
//   clk, rst_n : clock and synchronous active-low reset (count cleared)
//   load       : load load_val this cycle (has priority over counting)
//   load_val   : value to load
//   zero       : count has reached zero
// The count decrements freely and parks at zero.
module sccb_cfg_delay #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Camera register-table sequencer: walks a combinational config LUT from
// index 1 to CFG_NUM and issues one SCCB write per entry, with power-on
// delay, inter-write gap, delay-marker entries, NACK retry and restart.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : restart pulse, honoured in DONE/ERR only
//   lut_index, lut_data : config LUT index out, {reg_addr, reg_data} in
//   bus (master)        : write handshake to the I2C controller
//   cfg_busy/done/err   : run status
//   err_index           : entry that exhausted its retries
//
// state | meaning
// PWRON | waiting out the power-on delay
// FETCH | entry at lut_index decoded (write or delay marker)
// ISSUE | i2c_req held, waiting for i2c_done
// GAP   | idle after a write; re-issues if a retry is pending
// WAIT  | delay-marker wait
// DONE  | table finished cleanly
// ERR   | retries exhausted on err_index
module sccb_cfg_sequencer
   import sccb_cfg_pkg::*;
#(
   parameter int unsigned          CFG_NUM     = 3,
   parameter int                   IDX_W       = 8,
   parameter logic [FIELD_W-1:0]   DEV_ADDR    = 8'h42,
   parameter int unsigned          POWERON_DLY = 1000000,
   parameter int unsigned          WRITE_GAP   = 1000,
   parameter int unsigned          TICK_CYCLES = 50000,
   parameter int unsigned          MAX_RETRY   = 3,
   parameter logic [FIELD_W-1:0]   DLY_MARK    = DLY_MARK_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [IDX_W-1:0]      lut_index,
   input  logic [ENTRY_W-1:0]    lut_data,
   sccb_cfg_sequencer_if.master  bus,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   output logic                  cfg_err,
   output logic [IDX_W-1:0]      err_index
);

   localparam logic [63:0] MARK_MAX = 64'd255 * 64'(TICK_CYCLES);
   localparam logic [63:0] PG_MAX   = (64'(POWERON_DLY) > 64'(WRITE_GAP)) ?
                                      64'(POWERON_DLY) : 64'(WRITE_GAP);
   localparam logic [63:0] MAX_DLY  = (PG_MAX > MARK_MAX) ? PG_MAX : MARK_MAX;
   localparam int          CW       = (MAX_DLY == 64'd0) ? 1 : $clog2(MAX_DLY + 64'd1);
   localparam int          RW       = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

   // Counts load N-1 because the loading cycle is itself the first waited
   // cycle; a zero-length gap or power-on wait degenerates to one cycle.
   localparam logic [CW-1:0] PWRON_LOAD = (POWERON_DLY == 0) ? '0 : CW'(POWERON_DLY - 1);
   localparam logic [CW-1:0] GAP_LOAD   = (WRITE_GAP == 0)   ? '0 : CW'(WRITE_GAP - 1);

   cfg_state_t       state;
   logic             pwron_armed;
   logic [RW-1:0]    retry_cnt;
   logic             dly_load;
   logic [CW-1:0]    dly_val;
   logic             dly_zero;
   logic [CW-1:0]    mark_cnt;
   logic             is_mark;
   logic             last_entry;

   assign is_mark    = (entry_addr(lut_data) == DLY_MARK);
   assign mark_cnt   = CW'(entry_data(lut_data)) * CW'(TICK_CYCLES);
   assign last_entry = (lut_index == IDX_W'(CFG_NUM));
   assign bus.i2c_dev = DEV_ADDR;

   always_comb begin
      dly_load = 1'b0;
      dly_val  = '0;
      unique case (state)
         PWRON: if (!pwron_armed) begin
            dly_load = 1'b1;
            dly_val  = PWRON_LOAD;
         end
         FETCH: if (is_mark && mark_cnt != '0) begin
            dly_load = 1'b1;
            dly_val  = mark_cnt - CW'(1);
         end
         ISSUE: if (bus.i2c_done) begin
            dly_load = 1'b1;
            dly_val  = GAP_LOAD;
         end
         default: ;
      endcase
   end

   sccb_cfg_delay #(.CW(CW)) u_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dly_load),
      .load_val (dly_val),
      .zero     (dly_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= PWRON;
         pwron_armed   <= 1'b0;
         retry_cnt     <= '0;
         lut_index     <= '0;
         bus.i2c_req   <= 1'b0;
         bus.i2c_addr  <= '0;
         bus.i2c_wdata <= '0;
         cfg_busy      <= 1'b1;
         cfg_done      <= 1'b0;
         cfg_err       <= 1'b0;
         err_index     <= '0;
      end else begin
         unique case (state)
            PWRON: begin
               if (!pwron_armed) begin
                  pwron_armed <= 1'b1;
               end else if (dly_zero) begin
                  if (CFG_NUM == 0) begin
                     state    <= DONE;
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                  end else begin
                     lut_index <= IDX_W'(1);
                     state     <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (!is_mark) begin
                  bus.i2c_addr  <= entry_addr(lut_data);
                  bus.i2c_wdata <= entry_data(lut_data);
                  bus.i2c_req   <= 1'b1;
                  state         <= ISSUE;
               end else if (mark_cnt != '0) begin
                  state <= WAIT;
               end else if (last_entry) begin
                  state    <= DONE;
                  cfg_busy <= 1'b0;
                  cfg_done <= 1'b1;
               end else begin
                  lut_index <= lut_index + IDX_W'(1);
               end
            end
            ISSUE: begin
               if (bus.i2c_done) begin
                  bus.i2c_req <= 1'b0;
                  if (!bus.i2c_nack) begin
                     retry_cnt <= '0;
                     state     <= GAP;
                  end else if (retry_cnt != RW'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + RW'(1);
                     state     <= GAP;
                  end else begin
                     err_index <= lut_index;
                     cfg_err   <= 1'b1;
                     cfg_busy  <= 1'b0;
                     state     <= ERR;
                  end
               end
            end
            GAP: begin
               if (dly_zero) begin
                  // a non-zero retry count here can only mean the last attempt was NACKed
                  if (retry_cnt != '0) begin
                     bus.i2c_req <= 1'b1;
                     state       <= ISSUE;
                  end else if (last_entry) begin
                     state    <= DONE;
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                  end else begin
                     lut_index <= lut_index + IDX_W'(1);
                     state     <= FETCH;
                  end
               end
            end
            WAIT: begin
               if (dly_zero) begin
                  if (last_entry) begin
                     state    <= DONE;
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                  end else begin
                     lut_index <= lut_index + IDX_W'(1);
                     state     <= FETCH;
                  end
               end
            end
            DONE, ERR: begin
               if (start && CFG_NUM != 0) begin
                  cfg_done  <= 1'b0;
                  cfg_err   <= 1'b0;
                  retry_cnt <= '0;
                  cfg_busy  <= 1'b1;
                  lut_index <= IDX_W'(1);
                  state     <= FETCH;
               end
            end
            default: state <= PWRON;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
module tb_sccb_cfg_sequencer;

   localparam int CFG_NUM     = 3;
   localparam int POWERON_DLY = 10;
   localparam int WRITE_GAP   = 4;
   localparam int TICK_CYCLES = 5;
   localparam int MAX_RETRY   = 2;
   localparam int DONE_DLY    = 6;
   localparam int TMO         = 2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  lut_index;
   logic [15:0] lut_data;
   logic        cfg_busy, cfg_done, cfg_err;
   logic [7:0]  err_index;

   sccb_cfg_sequencer_if bus();

   sccb_cfg_sequencer #(
      .CFG_NUM     (CFG_NUM),
      .IDX_W       (8),
      .DEV_ADDR    (8'h42),
      .POWERON_DLY (POWERON_DLY),
      .WRITE_GAP   (WRITE_GAP),
      .TICK_CYCLES (TICK_CYCLES),
      .MAX_RETRY   (MAX_RETRY),
      .DLY_MARK    (8'hFF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .lut_index (lut_index),
      .lut_data  (lut_data),
      .bus       (bus),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .err_index (err_index)
   );

   always #5 clk = ~clk;

   // config LUT and per-entry NACK stimulus (leading NACK count; 9 = always)
   logic [15:0] lut [0:3];
   int          nacks [0:255];
   int          att   [0:255];

   assign lut_data = (lut_index <= 8'd3) ? lut[lut_index[1:0]] : 16'h0000;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         lat;
   } txn_t;

   txn_t exp_q[$];
   int   exp_end_lat;
   bit   exp_err;
   int   exp_err_idx;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
      end
   endtask

   // Reference model. Latencies count clock edges from the previous event
   // (reset release, start pulse, or the edge that sampled i2c_done):
   //   every entry costs one fetch cycle, a delay marker adds data*TICK_CYCLES,
   //   every completed write is followed by WRITE_GAP idle cycles, and a retry
   //   re-issues straight after the gap without a fetch.
   task automatic build_model(input int acc0);
      int         acc;
      logic [7:0] a, d;
      acc = acc0;
      exp_q.delete();
      exp_err     = 1'b0;
      exp_err_idx = 0;
      for (int e = 1; e <= CFG_NUM; e++) begin
         a = lut[e][15:8];
         d = lut[e][7:0];
         acc += 1;
         if (a == 8'hFF) begin
            acc += int'(d) * TICK_CYCLES;
            continue;
         end
         for (int t = 0; t <= MAX_RETRY; t++) begin
            exp_q.push_back('{a, d, acc});
            if (t >= nacks[e]) begin
               acc = WRITE_GAP;
               break;
            end
            if (t == MAX_RETRY) begin
               exp_err     = 1'b1;
               exp_err_idx = e;
               acc         = 0;
            end else begin
               acc = WRITE_GAP;
            end
         end
         if (exp_err) break;
      end
      exp_end_lat = acc;
   endtask

   task automatic set_lut(input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
                          input int n1, input int n2, input int n3);
      for (int i = 0; i < 256; i++) nacks[i] = 0;
      lut[0] = 16'h0000;
      lut[1] = e1;
      lut[2] = e2;
      lut[3] = e3;
      nacks[1] = n1;
      nacks[2] = n2;
      nacks[3] = n3;
   endtask

   task automatic check_reset();
      check("rst_index",     int'(lut_index),     0);
      check("rst_req",       int'(bus.i2c_req),   0);
      check("rst_addr",      int'(bus.i2c_addr),  0);
      check("rst_wdata",     int'(bus.i2c_wdata), 0);
      check("rst_busy",      int'(cfg_busy),      1);
      check("rst_done",      int'(cfg_done),      0);
      check("rst_err",       int'(cfg_err),       0);
      check("rst_err_index", int'(err_index),     0);
      check("dev_addr",      int'(bus.i2c_dev),   8'h42);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_clr_done", int'(cfg_done), 0);
      check("start_clr_err",  int'(cfg_err),  0);
      check("start_busy",     int'(cfg_busy), 1);
   endtask

   // Acts as the I2C controller (done DONE_DLY edges after req) and checks the
   // run against the model. abort_txn >= 0 pulses reset during that write.
   task automatic run_check(input bit mid_start, input int abort_txn);
      int         lat;
      int         idx;
      bit         nk;
      bit         stable;
      logic [7:0] ha, hd;
      for (int i = 0; i < 256; i++) att[i] = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         lat = 0;
         do begin
            @(posedge clk);
            #1;
            lat++;
            if (mid_start && k == 1) start = (lat == 2);
         end while (!bus.i2c_req && !cfg_done && !cfg_err && lat < TMO);
         start = 1'b0;
         check("req_latency", lat, exp_q[k].lat);
         if (!bus.i2c_req) return;
         check("req_addr",  int'(bus.i2c_addr),  int'(exp_q[k].a));
         check("req_wdata", int'(bus.i2c_wdata), int'(exp_q[k].d));
         check("busy_run",  int'(cfg_busy), 1);
         idx = int'(lut_index);
         nk  = (att[idx] < nacks[idx]);
         att[idx]++;
         ha = bus.i2c_addr;
         hd = bus.i2c_wdata;
         stable = 1'b1;
         for (int c = 1; c < DONE_DLY; c++) begin
            if (k == abort_txn && c == 2) begin
               rst_n = 1'b0;
               @(posedge clk);
               #1;
               check_reset();
               rst_n = 1'b1;
               return;
            end
            @(posedge clk);
            #1;
            if (!bus.i2c_req || bus.i2c_addr !== ha || bus.i2c_wdata !== hd) stable = 1'b0;
         end
         check("req_hold_stable", int'(stable), 1);
         bus.i2c_done = 1'b1;
         bus.i2c_nack = nk;
         @(posedge clk);
         #1;
         bus.i2c_done = 1'b0;
         bus.i2c_nack = 1'b0;
         check("req_drop", int'(bus.i2c_req), 0);
      end
      lat = 0;
      while (!cfg_done && !cfg_err && lat < TMO) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("end_latency", lat, exp_end_lat);
      check("end_done",    int'(cfg_done),    int'(!exp_err));
      check("end_err",     int'(cfg_err),     int'(exp_err));
      check("end_busy",    int'(cfg_busy),    0);
      check("end_req",     int'(bus.i2c_req), 0);
      if (exp_err) check("err_index", int'(err_index), exp_err_idx);
   endtask

   task automatic reset_release();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra;
      int         v;
      start        = 1'b0;
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      set_lut(16'h1100, 16'h1246, 16'h0cd0, 0, 0, 0);

      // nominal run from power-on
      reset_release();
      build_model(POWERON_DLY + 1);
      run_check(1'b0, -1);

      // delay marker
      set_lut(16'h1280, 16'hFF03, 16'h1246, 0, 0, 0);
      build_model(0);
      start_pulse();
      run_check(1'b0, -1);

      // retry success on entry 2
      set_lut(16'h1100, 16'h1246, 16'h0cd0, 0, 2, 0);
      build_model(0);
      start_pulse();
      run_check(1'b0, -1);

      // retry exhaustion on entry 3
      set_lut(16'h1100, 16'h1246, 16'h0cd0, 0, 0, 9);
      build_model(0);
      start_pulse();
      run_check(1'b0, -1);

      // restart from ERR with a start pulse mid-run, then restart from DONE
      set_lut(16'h1100, 16'h1246, 16'h0cd0, 0, 0, 0);
      build_model(0);
      start_pulse();
      run_check(1'b1, -1);
      build_model(0);
      start_pulse();
      run_check(1'b0, -1);

      // reset during an active write, then full power-on run
      build_model(0);
      start_pulse();
      run_check(1'b0, 0);
      build_model(POWERON_DLY + 1);
      run_check(1'b0, -1);

      // randomized tables and NACK patterns
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 256; i++) nacks[i] = 0;
         for (int e = 1; e <= CFG_NUM; e++) begin
            if ($urandom_range(0, 3) == 0) begin
               lut[e] = {8'hFF, 8'($urandom_range(0, 4))};
            end else begin
               ra     = 8'($urandom_range(0, 254));
               lut[e] = {ra, 8'($urandom_range(0, 255))};
            end
            v        = int'($urandom_range(0, 7));
            nacks[e] = (v < 5) ? 0 : v - 4;
         end
         build_model(0);
         start_pulse();
         run_check(1'b0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
